// File: rtl/code39_pkg.sv
// Shared definitions for the Code 39 decoder: FSM state codes, the start/stop
// pattern and the 44-entry symbol table (9 elements, bar first, 1 = wide).
package code39_pkg;

  // FSM state codes
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  typedef logic [1:0] state_t;

  // '*' start/stop character, oldest element in the MSB
  localparam logic [8:0] PAT_STAR = 9'b010010100;

  localparam int CODE39_ENTRIES = 44;

  typedef struct packed {
    logic [8:0] pattern;
    logic [7:0] ascii;
  } code39_entry_t;

  // Entry order is irrelevant to the lookup; grouped by the wide space position
  localparam code39_entry_t [CODE39_ENTRIES-1:0] CODE39_TABLE = {
    {9'b000110100, 8'h30}, // 0
    {9'b100100001, 8'h31}, // 1
    {9'b001100001, 8'h32}, // 2
    {9'b101100000, 8'h33}, // 3
    {9'b000110001, 8'h34}, // 4
    {9'b100110000, 8'h35}, // 5
    {9'b001110000, 8'h36}, // 6
    {9'b000100101, 8'h37}, // 7
    {9'b100100100, 8'h38}, // 8
    {9'b001100100, 8'h39}, // 9
    {9'b100001001, 8'h41}, // A
    {9'b001001001, 8'h42}, // B
    {9'b101001000, 8'h43}, // C
    {9'b000011001, 8'h44}, // D
    {9'b100011000, 8'h45}, // E
    {9'b001011000, 8'h46}, // F
    {9'b000001101, 8'h47}, // G
    {9'b100001100, 8'h48}, // H
    {9'b001001100, 8'h49}, // I
    {9'b000011100, 8'h4A}, // J
    {9'b100000011, 8'h4B}, // K
    {9'b001000011, 8'h4C}, // L
    {9'b101000010, 8'h4D}, // M
    {9'b000010011, 8'h4E}, // N
    {9'b100010010, 8'h4F}, // O
    {9'b001010010, 8'h50}, // P
    {9'b000000111, 8'h51}, // Q
    {9'b100000110, 8'h52}, // R
    {9'b001000110, 8'h53}, // S
    {9'b000010110, 8'h54}, // T
    {9'b110000001, 8'h55}, // U
    {9'b011000001, 8'h56}, // V
    {9'b111000000, 8'h57}, // W
    {9'b010010001, 8'h58}, // X
    {9'b110010000, 8'h59}, // Y
    {9'b011010000, 8'h5A}, // Z
    {9'b010000101, 8'h2D}, // -
    {9'b110000100, 8'h2E}, // .
    {9'b011000100, 8'h20}, // space
    {9'b010010100, 8'h2A}, // *
    {9'b010101000, 8'h24}, // $
    {9'b010100010, 8'h2F}, // /
    {9'b010001010, 8'h2B}, // +
    {9'b000101010, 8'h25}  // %
  };

endpackage

// File: rtl/code39_lookup.sv
// Combinational Code 39 pattern lookup: reports whether a 9-element
// narrow/wide pattern is a legal symbol and, if so, its ASCII value.
module code39_lookup
  import code39_pkg::*;
(
  input  logic [8:0] pattern,
  output logic       hit,
  output logic [7:0] ascii
);

  // Scan the whole table; patterns are unique so at most one entry matches
  always_comb begin
    hit   = 1'b0;
    ascii = 8'h00;
    for (int i = 0; i < CODE39_ENTRIES; i++) begin
      if (CODE39_TABLE[i].pattern == pattern) begin
        hit   = 1'b1;
        ascii = CODE39_TABLE[i].ascii;
      end
    end
  end

endmodule

// File: rtl/code39_decoder.sv
// Code 39 symbol decoder. Classifies incoming bar/space widths as narrow or
// wide, hunts for the '*' start character with a sliding window, then decodes
// 9-element data characters until the '*' stop character, handing each decoded
// character to the sink with a valid/ready handshake.
module code39_decoder
  import code39_pkg::*;
#(
  parameter int WIDE_THRESH = 6,
  parameter int SKIP_GAP    = 1,
  parameter int MAX_CHARS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] width_in,
  input  logic       width_valid,
  output logic       width_ready,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       frame_start,
  output logic       frame_end,
  output logic       err
);

  localparam int CW = $clog2(MAX_CHARS + 1);
  localparam logic [CW-1:0] CHAR_LIMIT = CW'(MAX_CHARS);
  // 9 bits so a threshold of 256 (everything narrow) is still representable
  localparam logic [8:0] WIDE_T = 9'(WIDE_THRESH);
  // Where a frame continues after the start character or an emitted character
  localparam state_t RESUME = (SKIP_GAP != 0) ? GAP : DATA;

  state_t        state;
  // The 8 previously accepted elements; together with the incoming element
  // they form the 9-element window that is matched and decoded.
  logic [7:0]    shift_reg;
  logic [3:0]    elem_cnt;
  logic [CW-1:0] char_cnt;
  logic [CW-1:0] char_cnt_inc;
  logic          accept;
  logic          elem_bit;
  logic [8:0]    shift_next;
  logic          lut_hit;
  logic [7:0]    lut_ascii;

  assign width_ready  = (state != EMIT);
  assign char_valid   = (state == EMIT);
  assign accept       = width_valid && width_ready;
  assign elem_bit     = ({1'b0, width_in} >= WIDE_T);
  assign shift_next   = {shift_reg, elem_bit};
  assign char_cnt_inc = char_cnt + CW'(1);

  code39_lookup u_lookup (
    .pattern (shift_next),
    .hit     (lut_hit),
    .ascii   (lut_ascii)
  );

  // Frame FSM, element window, counters and the registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      shift_reg   <= '0;
      elem_cnt    <= '0;
      char_cnt    <= '0;
      char_out    <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
      case (state)
        HUNT: begin
          if (accept) begin
            shift_reg <= shift_next[7:0];
            // elem_cnt saturates at 8: eight earlier elements plus this one
            // means the window is fully populated since entering HUNT
            if (elem_cnt == 4'd8 && shift_next == PAT_STAR) begin
              frame_start <= 1'b1;
              elem_cnt    <= '0;
              char_cnt    <= '0;
              state       <= RESUME;
            end else if (elem_cnt != 4'd8) begin
              elem_cnt <= elem_cnt + 4'd1;
            end
          end
        end
        GAP: begin
          if (accept) begin
            elem_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            shift_reg <= shift_next[7:0];
            if (elem_cnt == 4'd8) begin
              elem_cnt <= '0;
              if (shift_next == PAT_STAR) begin
                frame_end <= 1'b1;
                state     <= HUNT;
              end else if (lut_hit) begin
                char_out <= lut_ascii;
                state    <= EMIT;
              end else begin
                err   <= 1'b1;
                state <= HUNT;
              end
            end else begin
              elem_cnt <= elem_cnt + 4'd1;
            end
          end
        end
        EMIT: begin
          if (char_ready) begin
            char_cnt <= char_cnt_inc;
            if (char_cnt_inc == CHAR_LIMIT) begin
              err   <= 1'b1;
              state <= HUNT;
            end else begin
              state <= RESUME;
            end
          end
        end
        default: begin
          state    <= HUNT;
          elem_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code39_decoder.sv
// Self-checking bench for code39_decoder: directed scenarios with randomized
// element widths, checked against a frame parser built from the symbology.
module tb_code39_decoder;

  localparam int MAX_CHARS = 32;
  localparam logic [8:0] STAR = 9'b010010100;
  localparam int EV_START = 256;
  localparam int EV_END   = 257;
  localparam int EV_ERR   = 258;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] width_in;
  logic       width_valid;
  logic       width_ready;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       frame_start;
  logic       frame_end;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  bit stream[$];
  int exp_q[$];
  int got_q[$];
  int got_base = 0;
  bit clash_seen = 1'b0;

  // Symbology: characters grouped by which space is wide, ten bar pairs each
  string char_set = "1234567890ABCDEFGHIJKLMNOPQRSTUVWXYZ-. *$/+%";
  int space_pos[4] = '{3, 5, 7, 1};
  int bar_a[10]    = '{0, 2, 0, 4, 0, 2, 6, 0, 2, 4};
  int bar_b[10]    = '{8, 8, 2, 8, 4, 4, 8, 6, 6, 6};

  code39_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .width_in    (width_in),
    .width_valid (width_valid),
    .width_ready (width_ready),
    .char_out    (char_out),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .err         (err)
  );

  always #25 clk = ~clk;

  // Record every observable event away from the active edge
  always @(negedge clk) begin
    if (frame_start) got_q.push_back(EV_START);
    if (frame_end) got_q.push_back(EV_END);
    if (err) got_q.push_back(EV_ERR);
    if (frame_end && err) clash_seen = 1'b1;
    if (char_valid && char_ready) got_q.push_back(int'(char_out));
  end

  function automatic logic [8:0] model_pattern(input int idx);
    logic [8:0] p = '0;
    if (idx < 40) begin
      p[8 - space_pos[idx / 10]] = 1'b1;
      p[8 - bar_a[idx % 10]]     = 1'b1;
      p[8 - bar_b[idx % 10]]     = 1'b1;
    end else begin
      for (int s = 0; s < 4; s++)
        if (s != 43 - idx) p[8 - (2 * s + 1)] = 1'b1;
    end
    return p;
  endfunction

  function automatic void model_lookup(input logic [8:0] pat, output bit hit,
                                       output logic [7:0] asc);
    hit = 1'b0;
    asc = 8'h00;
    for (int idx = 0; idx < 44; idx++) begin
      if (model_pattern(idx) == pat) begin
        hit = 1'b1;
        asc = char_set[idx];
      end
    end
  endfunction

  function automatic logic [8:0] window_at(input int j);
    logic [8:0] w = '0;
    for (int k = 0; k < 9; k++) w[8 - k] = stream[j - 8 + k];
    return w;
  endfunction

  // Parse the element stream since reset into the expected event list
  function automatic void build_expected();
    int n = stream.size();
    int p = 0;
    int j;
    int nchar;
    bit done = 1'b0;
    bit found;
    bit in_frame;
    bit hit;
    logic [7:0] asc;
    logic [8:0] pat;
    exp_q.delete();
    while (!done) begin
      j = p + 8;
      found = 1'b0;
      while (!found && j < n) begin
        if (window_at(j) == STAR) found = 1'b1;
        else j++;
      end
      if (!found) begin
        done = 1'b1;
      end else begin
        exp_q.push_back(EV_START);
        p = j + 1;
        nchar = 0;
        in_frame = 1'b1;
        while (in_frame) begin
          if (p + 10 > n) begin
            in_frame = 1'b0;
            done = 1'b1;
          end else begin
            pat = window_at(p + 9);
            p = p + 10;
            if (pat == STAR) begin
              exp_q.push_back(EV_END);
              in_frame = 1'b0;
            end else begin
              model_lookup(pat, hit, asc);
              if (hit) begin
                exp_q.push_back(int'(asc));
                nchar++;
                if (nchar == MAX_CHARS) begin
                  exp_q.push_back(EV_ERR);
                  in_frame = 1'b0;
                end
              end else begin
                exp_q.push_back(EV_ERR);
                in_frame = 1'b0;
              end
            end
          end
        end
      end
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pick_width(input bit b, input bit fixed);
    int sel = $urandom_range(0, 7);
    if (fixed) return b ? 8'd8 : 8'd4;
    if (b) return (sel == 0) ? 8'd6 : 8'($urandom_range(6, 255));
    if (sel == 0) return 8'd5;
    if (sel == 1) return 8'd0;
    return 8'($urandom_range(1, 5));
  endfunction

  // Present one element and wait (bounded) for its handshake
  task automatic apply_stimulus(input logic [7:0] w, input bit b);
    int waited = 0;
    bit done = 1'b0;
    width_in = w;
    width_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (width_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check_output("width_ready_timeout", 32'(width_ready), 32'd1);
          done = 1'b1;
        end
      end
    end
    width_valid = 1'b0;
    stream.push_back(b);
  endtask

  task automatic send_pat(input logic [8:0] p, input bit fixed);
    for (int k = 8; k >= 0; k--) apply_stimulus(pick_width(p[k], fixed), p[k]);
  endtask

  task automatic send_gap(input bit fixed);
    bit b = fixed ? 1'b0 : 1'($urandom_range(0, 1));
    apply_stimulus(pick_width(b, fixed), b);
  endtask

  function automatic logic [8:0] rand_char();
    int idx = $urandom_range(0, 42);
    if (idx == 39) idx = 43;
    return model_pattern(idx);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    width_valid = 1'b0;
    width_in = 8'd0;
    char_ready = 1'b1;
    stream.delete();
    got_base = got_q.size();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_width_ready"}, 32'(width_ready), 32'd1);
    check_output({tag, "_char_valid"}, 32'(char_valid), 32'd0);
    check_output({tag, "_char_out"}, 32'(char_out), 32'd0);
    check_output({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check_output({tag, "_frame_end"}, 32'(frame_end), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_events(input string tag);
    int n_got;
    repeat (4) @(posedge clk);
    #1;
    build_expected();
    n_got = got_q.size() - got_base;
    check_output({tag, "_count"}, 32'(n_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_got; i++)
      check_output($sformatf("%s_ev%0d", tag, i), 32'(got_q[got_base + i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1;
    width_valid = 1'b0;
    width_in = 8'd0;
    char_ready = 1'b1;
    #1;
    check_reset_values("rst_active");
    apply_reset();
    check_reset_values("rst_release");

    // Basic frame with fixed widths: '*' gap 'A' gap '*'
    send_pat(STAR, 1'b1);
    check_output("s1_frame_start", 32'(frame_start), 32'd1);
    send_gap(1'b1);
    send_pat(9'b100001001, 1'b1);
    check_output("s1_char_valid", 32'(char_valid), 32'd1);
    check_output("s1_char_out", 32'(char_out), 32'h41);
    check_output("s1_ready_low", 32'(width_ready), 32'd0);
    send_gap(1'b1);
    send_pat(STAR, 1'b1);
    check_output("s1_frame_end", 32'(frame_end), 32'd1);
    check_output("s1_no_err", 32'(err), 32'd0);
    check_events("s1");

    // Leading noise before the start character
    apply_stimulus(8'd8, 1'b1);
    apply_stimulus(8'd4, 1'b0);
    apply_stimulus(8'd8, 1'b1);
    send_pat(STAR, 1'b1);
    send_gap(1'b1);
    send_pat(9'b000110100, 1'b1);
    check_output("s2_char_out", 32'(char_out), 32'h30);
    send_gap(1'b1);
    send_pat(STAR, 1'b1);
    check_events("s2");

    // Sink stalls while '1' is held
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    char_ready = 1'b0;
    send_pat(9'b100100001, 1'b0);
    width_in = 8'd8;
    width_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_output("s3_hold_valid", 32'(char_valid), 32'd1);
      check_output("s3_hold_char", 32'(char_out), 32'h31);
      check_output("s3_hold_ready", 32'(width_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    width_valid = 1'b0;
    char_ready = 1'b1;
    send_gap(1'b0);
    send_pat(STAR, 1'b0);
    check_events("s3");

    // Invalid patterns abort the frame; later frames still decode
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    send_pat(9'b100000000, 1'b0);
    check_output("s4_err", 32'(err), 32'd1);
    check_output("s4_no_end", 32'(frame_end), 32'd0);
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    send_pat(9'b001001001, 1'b0);
    send_gap(1'b0);
    send_pat(STAR, 1'b0);
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    send_pat(9'b111100000, 1'b0);
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    send_pat(STAR, 1'b0);
    check_events("s4");

    // Longest legal frame, then one that overflows
    send_pat(STAR, 1'b0);
    for (int c = 0; c < MAX_CHARS - 1; c++) begin
      send_gap(1'b0);
      send_pat(rand_char(), 1'b0);
    end
    send_gap(1'b0);
    send_pat(STAR, 1'b0);
    send_pat(STAR, 1'b0);
    for (int c = 0; c < MAX_CHARS + 1; c++) begin
      send_gap(1'b0);
      send_pat(rand_char(), 1'b0);
    end
    send_gap(1'b0);
    send_pat(STAR, 1'b0);
    check_events("s5");

    // Reset in the middle of a data character
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    for (int k = 8; k >= 4; k--) apply_stimulus(pick_width(STAR[k], 1'b0), STAR[k]);
    check_events("s6_pre");
    rst = 1'b1;
    stream.delete();
    got_base = got_q.size();
    #1;
    check_reset_values("s6_mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_pat(STAR, 1'b0);
    send_gap(1'b0);
    send_pat(9'b101001000, 1'b0);
    send_gap(1'b0);
    send_pat(STAR, 1'b0);
    check_events("s6");

    // Random frames with occasional noise and arbitrary patterns
    for (int f = 0; f < 6; f++) begin
      int nch = $urandom_range(0, 5);
      for (int k = 0; k < $urandom_range(0, 4); k++) begin
        bit b = 1'($urandom_range(0, 1));
        apply_stimulus(pick_width(b, 1'b0), b);
      end
      send_pat(STAR, 1'b0);
      for (int c = 0; c < nch; c++) begin
        send_gap(1'b0);
        if ($urandom_range(0, 5) == 0) send_pat(9'($urandom_range(0, 511)), 1'b0);
        else send_pat(rand_char(), 1'b0);
      end
      send_gap(1'b0);
      send_pat(STAR, 1'b0);
    end
    check_events("s7");

    check_output("end_err_exclusive", 32'(clash_seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
